// File: rtl/instr_encoder.sv
// RV64I instruction encoder: packs decoded fields and a signed immediate into a
// 32-bit word behind one registered valid/ready stage, tagging each word with its address.
module instr_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [63:0] in_imm,
    input  logic        in_pcrel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_addr,
    output logic        out_err,
    output logic [15:0] err_count
);

    logic [63:0]        addr_q;
    logic signed [63:0] off;
    logic [31:0]        enc;
    logic               enc_err;
    logic               accept;
    logic               drain;
    logic               pcrel_used;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign drain      = out_valid && out_ready;
    assign pcrel_used = in_pcrel && (in_type == 3'd3 || in_type == 3'd5);
    assign off        = pcrel_used ? in_imm - addr_q : in_imm;

    // Field packing and range check; the truncated encoding is emitted even on error.
    always_comb begin
        enc     = 32'h0;
        enc_err = 1'b0;
        case (in_type)
            3'd0: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: begin
                enc     = {off[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_err = (off < -64'sd2048) || (off > 64'sd2047);
            end
            3'd2: begin
                enc     = {off[11:5], in_rs2, in_rs1, in_funct3, off[4:0], in_opcode};
                enc_err = (off < -64'sd2048) || (off > 64'sd2047);
            end
            3'd3: begin
                enc     = {off[12], off[10:5], in_rs2, in_rs1, in_funct3, off[4:1], off[11], in_opcode};
                enc_err = (off < -64'sd4096) || (off > 64'sd4094) || off[0];
            end
            3'd4: begin
                enc     = {off[31:12], in_rd, in_opcode};
                enc_err = (|off[11:0]) || !((&off[63:31]) || !(|off[63:31]));
            end
            3'd5: begin
                enc     = {off[20], off[10:1], off[11], off[19:12], in_rd, in_opcode};
                enc_err = (off < -64'sd1048576) || (off > 64'sd1048574) || off[0];
            end
            default: begin
                enc     = 32'h0000_0013;
                enc_err = 1'b1;
            end
        endcase
    end

    // Output stage and address counter; reset/clear win over any handshake that cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_addr  <= 64'h0;
            out_err   <= 1'b0;
            err_count <= 16'h0;
            addr_q    <= BASE_ADDR;
        end else begin
            if (drain && out_err && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= enc;
                out_addr  <= addr_q;
                out_err   <= enc_err;
                addr_q    <= addr_q + 64'(ADDR_STEP);
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal cases, backpressure and
// clear scenarios, then randomized traffic checked against a behavioural queue model.
module tb_instr_encoder;

    localparam logic [63:0] BASE = 64'h0;
    localparam int unsigned STEP = 4;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, in_ready, in_pcrel;
    logic [2:0]  in_type, in_funct3;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [63:0] in_imm;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    bit checking_on = 0;
    bit rec_hs = 0;
    logic [63:0] hs[$];

    typedef struct {
        logic [31:0] instr;
        logic [63:0] addr;
        bit          err;
    } exp_t;

    exp_t        expq[$];
    logic [63:0] m_addr = BASE;
    logic [15:0] m_errcnt = 16'h0;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_pcrel(in_pcrel),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference encoder expressed as arithmetic on the offset value.
    function automatic void modelEncode(input int t, input longint unsigned op, rd, rs1, rs2, f3, f7,
                                        input longint imm, input bit pcrel, input longint addr,
                                        output logic [31:0] instr, output bit err);
        longint off;
        longint unsigned u, w, common;
        off    = (pcrel && (t == 3 || t == 5)) ? imm - addr : imm;
        u      = off;
        w      = 0;
        err    = 0;
        common = (rs1 << 15) | (f3 << 12) | op;
        case (t)
            0: w = (f7 << 25) | (rs2 << 20) | common | (rd << 7);
            1: begin
                w   = ((u % 4096) << 20) | common | (rd << 7);
                err = (off < -2048) || (off > 2047);
            end
            2: begin
                w   = ((u / 32 % 128) << 25) | (rs2 << 20) | common | ((u % 32) << 7);
                err = (off < -2048) || (off > 2047);
            end
            3: begin
                w   = ((u / 4096 % 2) << 31) | ((u / 32 % 64) << 25) | (rs2 << 20) | common
                    | ((u / 2 % 16) << 8) | ((u / 2048 % 2) << 7);
                err = (off < -4096) || (off > 4094) || (u % 2 == 1);
            end
            4: begin
                w   = ((u / 4096 % 1048576) << 12) | (rd << 7) | op;
                err = (u % 4096 != 0) || (off < -64'sd2147483648) || (off > 64'sd2147483647);
            end
            5: begin
                w   = ((u / 1048576 % 2) << 31) | ((u / 2 % 1024) << 21) | ((u / 2048 % 2) << 20)
                    | ((u / 4096 % 256) << 12) | (rd << 7) | op;
                err = (off < -1048576) || (off > 1048574) || (u % 2 == 1);
            end
            default: begin
                w   = 'h13;
                err = 1;
            end
        endcase
        instr = w[31:0];
    endfunction

    // Per-cycle compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        bit          mvalid;
        exp_t        e;
        logic [31:0] mi;
        bit          me;
        if (checking_on) begin
            mvalid = expq.size() != 0;
            checkOutput("out_valid", 64'(out_valid), 64'(mvalid));
            checkOutput("in_ready", 64'(in_ready), 64'(!mvalid || out_ready));
            checkOutput("err_count", 64'(err_count), 64'(m_errcnt));
            if (mvalid) begin
                checkOutput("out_instr", 64'(out_instr), 64'(expq[0].instr));
                checkOutput("out_addr", out_addr, expq[0].addr);
                checkOutput("out_err", 64'(out_err), 64'(expq[0].err));
            end
            if (reset || clear) begin
                expq.delete();
                m_addr   = BASE;
                m_errcnt = 16'h0;
            end else begin
                if (out_valid && out_ready && rec_hs) hs.push_back(out_addr);
                if (mvalid && out_ready) begin
                    if (expq[0].err && m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 16'd1;
                    void'(expq.pop_front());
                end
                if (in_valid && (!mvalid || out_ready)) begin
                    modelEncode(int'(in_type), longint'(in_opcode), longint'(in_rd), longint'(in_rs1),
                                longint'(in_rs2), longint'(in_funct3), longint'(in_funct7),
                                longint'(in_imm), in_pcrel, longint'(m_addr), mi, me);
                    e.instr = mi;
                    e.addr  = m_addr;
                    e.err   = me;
                    expq.push_back(e);
                    m_addr = m_addr + 64'(STEP);
                end
            end
        end
    end

    task automatic setFields(input int t, op, rd, rs1, rs2, f3, f7, input longint imm, input bit pcrel);
        in_type   = 3'(t);
        in_opcode = 7'(op);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = 64'(imm);
        in_pcrel  = pcrel;
    endtask

    // Holds in_valid until the word is accepted; returns one step after the accepting edge.
    task automatic applyStimulus(input int t, op, rd, rs1, rs2, f3, f7, input longint imm, input bit pcrel);
        int n   = 0;
        bit acc = 0;
        setFields(t, op, rd, rs1, rs2, f3, f7, imm, pcrel);
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) checkOutput("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic directedWord(input string name, input int t, op, rd, rs1, rs2, f3, f7,
                                input longint imm, input bit pcrel,
                                input logic [31:0] xi, input logic [63:0] xa, input bit xe);
        logic [31:0] mi;
        bit          me;
        modelEncode(t, op, rd, rs1, rs2, f3, f7, imm, pcrel, longint'(xa), mi, me);
        checkOutput({name, "_model"}, 64'(mi), 64'(xi));
        applyStimulus(t, op, rd, rs1, rs2, f3, f7, imm, pcrel);
        checkOutput({name, "_instr"}, 64'(out_instr), 64'(xi));
        checkOutput({name, "_addr"}, out_addr, xa);
        checkOutput({name, "_err"}, 64'(out_err), 64'(xe));
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    function automatic longint randImm();
        longint bl[17] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098,
                           -1048576, 1048574, 1048576, -1048578, 64'sh7ffff000,
                           -64'sd2147483648, 64'sd2147483648, 0};
        case ($urandom_range(0, 5))
            0:       return longint'($urandom_range(0, 8191)) - 4096;
            1:       return bl[$urandom_range(0, 16)];
            2:       return {$urandom, $urandom};
            3:       return longint'($urandom_range(0, 4194303)) - 2097152;
            4:       return longint'($signed($urandom)) & ~64'hfff;
            default: return longint'($urandom_range(0, 2047)) * 2;
        endcase
    endfunction

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        setFields(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checking_on = 1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
        checkOutput("rst_out_addr", out_addr, 64'd0);
        checkOutput("rst_out_err", 64'(out_err), 64'd0);
        checkOutput("rst_err_count", 64'(err_count), 64'd0);

        directedWord("i_pos", 1, 'h13, 1, 0, 0, 0, 0, 5, 0, 32'h00500093, 64'd0, 0);
        directedWord("i_neg", 1, 'h13, 1, 0, 0, 0, 0, -1, 0, 32'hfff00093, 64'd4, 0);
        directedWord("s_sd", 2, 'h23, 0, 2, 1, 3, 0, 8, 0, 32'h00113423, 64'd8, 0);
        directedWord("r_zero", 0, 'h33, 0, 0, 0, 0, 0, 0, 0, 32'h00000033, 64'd12, 0);

        pulseClear();
        repeat (3) applyStimulus(0, 'h33, 0, 0, 0, 0, 0, 0, 0);
        directedWord("b_pcrel", 3, 'h63, 0, 0, 0, 0, 0, 4, 1, 32'hfe000ce3, 64'd12, 0);

        directedWord("i_2048", 1, 'h13, 1, 0, 0, 0, 0, 2048, 0, 32'h80000093, 64'd16, 1);
        @(posedge clk);
        #1;
        checkOutput("errcnt_one", 64'(err_count), 64'd1);
        directedWord("b_even", 3, 'h63, 0, 0, 0, 0, 0, 6, 0, 32'h00000363, 64'd20, 0);
        directedWord("b_odd", 3, 'h63, 0, 0, 0, 0, 0, 7, 0, 32'h00000363, 64'd24, 1);
        directedWord("u_low", 4, 'h37, 0, 0, 0, 0, 0, 'h12345001, 0, 32'h12345037, 64'd28, 1);
        directedWord("illegal", 6, 'h7f, 5, 3, 4, 7, 'h7f, 99, 1, 32'h00000013, 64'd32, 1);
        @(posedge clk);
        #1;
        checkOutput("errcnt_four", 64'(err_count), 64'd4);

        // clear during simultaneous input and output handshakes
        out_ready = 1'b0;
        applyStimulus(0, 'h33, 1, 0, 0, 0, 0, 0, 0);
        setFields(1, 'h13, 2, 0, 0, 0, 0, 3, 0);
        in_valid = 1'b1; out_ready = 1'b1; clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0;
        checkOutput("clr_out_valid", 64'(out_valid), 64'd0);
        checkOutput("clr_err_count", 64'(err_count), 64'd0);
        directedWord("clr_next", 1, 'h13, 1, 0, 0, 0, 0, 5, 0, 32'h00500093, BASE, 0);

        // backpressure mid-burst
        pulseClear();
        hs.delete();
        rec_hs = 1;
        applyStimulus(0, 'h33, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 'h33, 2, 0, 0, 0, 0, 0, 0);
        out_ready = 1'b0;
        setFields(0, 'h33, 3, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_hold_addr", out_addr, 64'd4);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(0, 'h33, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 'h33, 4, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rec_hs = 0;
        checkOutput("bp_count", 64'(hs.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("bp_addr%0d", i), (i < hs.size()) ? hs[i] : 64'hdead, 64'(i * 4));

        // randomized traffic with occasional clear and reset
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            setFields(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 127)), randImm(), 1'($urandom_range(0, 1)));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            clear     = ($urandom_range(0, 99) == 0);
            reset     = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; clear = 1'b0; reset = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("drained", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV64I instruction encoder; the inverse of the immediate generator.
- Accepts decoded fields plus a 64-bit signed immediate and packs them into a 32-bit instruction word.
- Range-checks the immediate and tags each output with its instruction-memory address.
- Feeds the instruction-memory preloader and the decoder self-check bench; one registered output stage with valid/ready on both sides.

Parameters:
- BASE_ADDR, 64'h0, address assigned to the first instruction after reset or clear.
- ADDR_STEP, 4, address increment per emitted instruction.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous restart: address back to BASE_ADDR, error count zeroed, output stage emptied
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept this cycle
- in_type  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_opcode  in  7  opcode[6:0]
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7, used for R only
- in_imm  in  64  signed immediate, or absolute target when in_pcrel=1
- in_pcrel  in  1  B/J only: encoded offset = in_imm - current address
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded instruction
- out_addr  out  64  address of out_instr
- out_err  out  1  immediate out of range, misaligned, or illegal type
- err_count  out  16  saturating count of emitted words with out_err=1

Behaviour:
- Reset (and clear): out_valid=0, out_instr=0, out_addr=0, out_err=0, err_count=0, address counter=BASE_ADDR.
- in_ready = !out_valid || out_ready (combinational).
- Input handshake on in_valid&&in_ready. Output register loads on the next edge, giving 1-cycle latency.
- Output handshake on out_valid&&out_ready. Back-to-back throughput is 1 word/cycle.
- Address counter: the accepted word takes the current counter value into out_addr; the counter then advances by ADDR_STEP. The counter wraps modulo 2^64.
- Offset: off = in_pcrel ? in_imm - addr : in_imm, 64-bit two's complement. in_pcrel is ignored for types other than B/J.
- Common field placement: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20].
- R: funct7 at [31:25]. Never sets err.
- I: off[11:0] at [31:20]. err if off not in [-2048, 2047].
- S: off[11:5] at [31:25], off[4:0] at [11:7]. err if off not in [-2048, 2047].
- B: off[12] at [31], off[10:5] at [30:25], off[4:1] at [11:8], off[11] at [7]. err if off not in [-4096, 4094] or off[0]=1.
- U: off[31:12] at [31:12]. err if off[11:0]!=0 or off[63:31] is not all-equal (sign extension).
- J: off[20] at [31], off[10:1] at [30:21], off[11] at [20], off[19:12] at [19:12]. err if off not in [-2^20, 2^20-2] or off[0]=1.
- Fields unused by a type are zero.
- On err, out_instr still carries the truncated encoding. Exception: illegal type emits 32'h00000013 (nop) with err=1.
- err_count increments on each output handshake with out_err=1 and saturates at 16'hFFFF.
- Output held stable while out_valid && !out_ready; no input is accepted in that state.
- clear and reset take priority over any simultaneous handshake. An accepted input in the same cycle is dropped; a pending output word is discarded.
- reset asserted mid-stream behaves identically to clear.

Test Plan:
- I: opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_instr=0x00500093, out_addr=0, err=0. Same with imm=-1 -> 0xfff00093.
- S: opcode 0x23, funct3=3, rs1=2, rs2=1, imm=8 -> 0x00113423. R: all fields 0, opcode 0x33 -> 0x00000033.
- B, pcrel: skip 3 words so addr=12; beq opcode 0x63, rs1=rs2=0, imm=4, in_pcrel=1 -> off=-8, out_instr=0xfe000ce3, out_addr=12, err=0.
- Range: I imm=2048 -> err=1, err_count=1. B imm=6 (odd bit clear, in range) -> err=0; B imm=7 -> err=1. U imm=0x12345001 -> err=1. type=6 -> 0x00000013, err=1.
- Backpressure: stream 4 words with out_ready low for 3 cycles mid-burst -> in_ready=0 while stalled, no word lost or duplicated, out_addr sequence 0,4,8,12.
- clear asserted during a handshake -> pending word dropped, out_valid=0, next accepted word out_addr=BASE_ADDR, err_count=0.
